ps2_host_controller: RTL and testbench

- Host (FPGA) end of the PS/2 link driven by the testbench keyboard device model.
- Receives device-to-host frames (scan codes, ACK 0xFA, echo 0xEE) and presents each byte with a one-cycle strobe.
- Transmits host-to-device command bytes (0xED, 0xEE, 0xF4, 0xF5, LED argument) using the request-to-send sequence.
- Drives the shared open-drain ps2_clk/ps2_dat lines: each line is driven either 0 or z, never 1.

---
 rtl/ps2_host_controller.sv | 201 ++++++++++++++++++++
 tb/tb_ps2_host_controller.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_controller.sv
// PS/2 host controller: receives device frames and transmits command bytes using the
// request-to-send sequence. The shared lines are only ever pulled low or released.
module ps2_host_controller #(
    parameter int CLOCK_CYCLES_FOR_100US     = 5000,
    parameter int NUMBER_OF_BITS_FOR_100US   = 13,
    parameter int CLOCK_CYCLES_FOR_TIMEOUT   = 750000,
    parameter int NUMBER_OF_BITS_FOR_TIMEOUT = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] the_command,
    input  logic       send_command,
    inout  wire        ps2_clk,
    inout  wire        ps2_dat,
    output logic [7:0] received_data,
    output logic       received_data_en,
    output logic       command_was_sent,
    output logic       error_communication_timed_out,
    output logic       error_frame,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        RX_DATA,
        TX_INHIBIT,
        TX_DATA,
        TX_ACK
    } state_t;

    localparam logic [NUMBER_OF_BITS_FOR_100US-1:0] INHIBIT_ONE = 1;
    localparam logic [NUMBER_OF_BITS_FOR_100US-1:0] INHIBIT_DAT_LOW =
        NUMBER_OF_BITS_FOR_100US'(CLOCK_CYCLES_FOR_100US - 2);
    localparam logic [NUMBER_OF_BITS_FOR_100US-1:0] INHIBIT_LAST =
        NUMBER_OF_BITS_FOR_100US'(CLOCK_CYCLES_FOR_100US - 1);
    localparam logic [NUMBER_OF_BITS_FOR_TIMEOUT-1:0] TIMEOUT_ONE = 1;
    localparam logic [NUMBER_OF_BITS_FOR_TIMEOUT-1:0] TIMEOUT_MAX =
        NUMBER_OF_BITS_FOR_TIMEOUT'(CLOCK_CYCLES_FOR_TIMEOUT);

    state_t                                state;
    logic [1:0]                            clk_sync;
    logic [1:0]                            dat_sync;
    logic                                  clk_prev;
    logic                                  clk_fe;
    logic                                  dat_s;
    logic                                  timed_out;
    logic [3:0]                            bit_cnt;
    logic [8:0]                            rx_shift;
    logic [9:0]                            tx_frame;
    logic [NUMBER_OF_BITS_FOR_100US-1:0]   inhibit_cnt;
    logic [NUMBER_OF_BITS_FOR_TIMEOUT-1:0] timeout_cnt;
    logic                                  drive_clk_low;
    logic                                  drive_dat_low;

    // NOTE: the outputs are either 0 or z; driving a 1 would fight the device on the bus.
    assign ps2_clk = drive_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = drive_dat_low ? 1'b0 : 1'bz;

    assign dat_s     = dat_sync[1];
    assign clk_fe    = clk_prev & ~clk_sync[1];
    assign timed_out = (timeout_cnt == TIMEOUT_MAX);

    // NOTE: synchronizers reset to 1 (idle bus) so leaving reset never fakes a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            clk_prev <= clk_sync[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                         <= IDLE;
            bit_cnt                       <= '0;
            rx_shift                      <= '0;
            tx_frame                      <= '0;
            inhibit_cnt                   <= '0;
            timeout_cnt                   <= '0;
            drive_clk_low                 <= 1'b0;
            drive_dat_low                 <= 1'b0;
            received_data                 <= 8'h00;
            received_data_en              <= 1'b0;
            command_was_sent              <= 1'b0;
            error_communication_timed_out <= 1'b0;
            error_frame                   <= 1'b0;
            busy                          <= 1'b0;
        end else begin
            received_data_en              <= 1'b0;
            command_was_sent              <= 1'b0;
            error_communication_timed_out <= 1'b0;
            error_frame                   <= 1'b0;

            case (state)
                IDLE: begin
                    drive_clk_low <= 1'b0;
                    drive_dat_low <= 1'b0;
                    bit_cnt       <= '0;
                    inhibit_cnt   <= '0;
                    timeout_cnt   <= '0;
                    // A pending command wins over a start bit arriving in the same cycle.
                    if (send_command) begin
                        tx_frame      <= {1'b1, ~^the_command, the_command};
                        drive_clk_low <= 1'b1;
                        busy          <= 1'b1;
                        state         <= TX_INHIBIT;
                    end else if (clk_fe && !dat_s) begin
                        busy  <= 1'b1;
                        state <= RX_DATA;
                    end
                end

                RX_DATA: begin
                    if (clk_fe) begin
                        timeout_cnt <= '0;
                        bit_cnt     <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd9) begin
                            // rx_shift holds d0..d7 and parity; dat_s is the stop bit.
                            if ((^rx_shift) && dat_s) begin
                                received_data    <= rx_shift[7:0];
                                received_data_en <= 1'b1;
                            end else begin
                                error_frame <= 1'b1;
                            end
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            rx_shift <= {dat_s, rx_shift[8:1]};
                        end
                    end else if (timed_out) begin
                        error_communication_timed_out <= 1'b1;
                        busy                          <= 1'b0;
                        state                         <= IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + TIMEOUT_ONE;
                    end
                end

                TX_INHIBIT, TX_DATA, TX_ACK: begin
                    if (timed_out) begin
                        drive_clk_low                 <= 1'b0;
                        drive_dat_low                 <= 1'b0;
                        error_communication_timed_out <= 1'b1;
                        busy                          <= 1'b0;
                        state                         <= IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + TIMEOUT_ONE;
                        case (state)
                            TX_INHIBIT: begin
                                inhibit_cnt <= inhibit_cnt + INHIBIT_ONE;
                                // Start bit goes low one cycle before the clock is released.
                                if (inhibit_cnt == INHIBIT_DAT_LOW) begin
                                    drive_dat_low <= 1'b1;
                                end
                                if (inhibit_cnt == INHIBIT_LAST) begin
                                    drive_clk_low <= 1'b0;
                                    bit_cnt       <= '0;
                                    state         <= TX_DATA;
                                end
                            end

                            TX_DATA: begin
                                if (clk_fe) begin
                                    drive_dat_low <= ~tx_frame[bit_cnt];
                                    bit_cnt       <= bit_cnt + 4'd1;
                                    if (bit_cnt == 4'd9) begin
                                        state <= TX_ACK;
                                    end
                                end
                            end

                            TX_ACK: begin
                                if (clk_fe) begin
                                    if (!dat_s) begin
                                        command_was_sent <= 1'b1;
                                    end else begin
                                        error_frame <= 1'b1;
                                    end
                                    busy  <= 1'b0;
                                    state <= IDLE;
                                end
                            end

                            default: ;
                        endcase
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_controller.sv
// Directed bench for ps2_host_controller with a PS/2 keyboard model on the open-drain bus.
module tb_ps2_host_controller;

    localparam int T100 = 20;
    localparam int TOUT = 200;
    localparam int H    = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] the_command;
    logic       send_command;
    wire        ps2_clk;
    wire        ps2_dat;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       command_was_sent;
    logic       error_communication_timed_out;
    logic       error_frame;
    logic       busy;

    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;

    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_dat);

    ps2_host_controller #(
        .CLOCK_CYCLES_FOR_100US    (T100),
        .NUMBER_OF_BITS_FOR_100US  (13),
        .CLOCK_CYCLES_FOR_TIMEOUT  (TOUT),
        .NUMBER_OF_BITS_FOR_TIMEOUT(20)
    ) dut (
        .clk                          (clk),
        .reset                        (reset),
        .the_command                  (the_command),
        .send_command                 (send_command),
        .ps2_clk                      (ps2_clk),
        .ps2_dat                      (ps2_dat),
        .received_data                (received_data),
        .received_data_en             (received_data_en),
        .command_was_sent             (command_was_sent),
        .error_communication_timed_out(error_communication_timed_out),
        .error_frame                  (error_frame),
        .busy                         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Strobe monitor: counts high cycles so a stretched pulse shows up as an extra count.
    int         rx_en_cycles = 0;
    int         sent_cycles  = 0;
    int         ferr_cycles  = 0;
    int         tout_cycles  = 0;
    int         multi_cycles = 0;
    logic [7:0] rx_q[$];

    int exp_rx   = 0;
    int exp_sent = 0;
    int exp_ferr = 0;
    int exp_tout = 0;

    // Keyboard model state.
    logic       kb_enabled    = 1'b1;
    logic       kb_expect_led = 1'b0;
    logic [2:0] lock_controls = 3'b000;
    logic [7:0] pending[$];

    always @(negedge clk) begin
        if (received_data_en) begin
            rx_en_cycles++;
            rx_q.push_back(received_data);
        end
        if (command_was_sent)              sent_cycles++;
        if (error_frame)                   ferr_cycles++;
        if (error_communication_timed_out) tout_cycles++;
        if (int'(received_data_en) + int'(command_was_sent) + int'(error_frame)
            + int'(error_communication_timed_out) > 1) multi_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_counts(input string tag);
        check({tag, " rx_en cycles"}, rx_en_cycles, exp_rx);
        check({tag, " sent cycles"}, sent_cycles, exp_sent);
        check({tag, " frame err cycles"}, ferr_cycles, exp_ferr);
        check({tag, " timeout cycles"}, tout_cycles, exp_tout);
    endtask

    function automatic logic [31:0] pop_rx();
        if (rx_q.size() == 0) return 32'hDEAD_BEEF;
        return {24'h0, rx_q.pop_front()};
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Device-to-host frame; parity can be flipped and the stop bit chosen.
    task automatic dev_send(input logic [7:0] b, input logic flip_parity, input logic stop_bit);
        logic [10:0] frame;
        frame = {stop_bit, (~^b) ^ flip_parity, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            dev_dat_low = ~frame[i];
            wait_cycles(H);
            dev_clk_low = 1'b1;
            wait_cycles(H);
            dev_clk_low = 1'b0;
        end
        wait_cycles(H);
        dev_dat_low = 1'b0;
    endtask

    // First n bits of a frame (start bit first), then the device goes quiet.
    task automatic dev_partial(input logic [3:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            dev_dat_low = ~bits[i];
            wait_cycles(H);
            dev_clk_low = 1'b1;
            wait_cycles(H);
            dev_clk_low = 1'b0;
        end
    endtask

    // Device side of host-to-device: measure the inhibit, clock 10 bits in, then ACK (or not).
    task automatic dev_recv_cmd(input logic nack, output logic [9:0] bits,
                                output int low_c, output int ovl, output logic ok);
        int guard;
        ok    = 1'b1;
        low_c = 0;
        ovl   = 0;
        bits  = '0;
        guard = 0;
        while (ps2_clk !== 1'b0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (ps2_clk !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        while (ps2_clk === 1'b0 && low_c < 1000) begin
            low_c++;
            if (ps2_dat === 1'b0) ovl++;
            @(negedge clk);
        end
        if (ps2_dat !== 1'b0) ok = 1'b0;
        wait_cycles(H);
        for (int i = 0; i < 10; i++) begin
            dev_clk_low = 1'b1;
            wait_cycles(H);
            dev_clk_low = 1'b0;
            wait_cycles(H);
            bits[i] = ps2_dat;
        end
        dev_dat_low = ~nack;
        wait_cycles(H);
        dev_clk_low = 1'b1;
        wait_cycles(H);
        dev_clk_low = 1'b0;
        wait_cycles(H);
        dev_dat_low = 1'b0;
    endtask

    task automatic do_command(input logic [7:0] cmd, input logic exp_par, input logic nack,
                              output logic [7:0] got);
        logic [9:0] bits;
        int         low_c;
        int         ovl;
        logic       ok;
        @(negedge clk);
        the_command  = cmd;
        send_command = 1'b1;
        @(negedge clk);
        send_command = 1'b0;
        the_command  = 8'h00;
        check("busy during tx", busy, 1);
        dev_recv_cmd(nack, bits, low_c, ovl, ok);
        check("rts sequence seen", ok, 1);
        check("inhibit low cycles", low_c, T100);
        check("start overlap cycles", ovl, 1);
        check("tx byte", bits[7:0], cmd);
        check("tx parity", bits[8], exp_par);
        check("tx stop", bits[9], 1);
        wait_cycles(6);
        if (nack) exp_ferr++;
        else      exp_sent++;
        check_counts("after command");
        check("busy after ack", busy, 0);
        got = bits[7:0];
    endtask

    task automatic kb_respond(input logic [7:0] b);
        logic [7:0] resp;
        resp = 8'hFA;
        if (kb_expect_led) begin
            lock_controls = b[2:0];
            kb_expect_led = 1'b0;
        end else begin
            case (b)
                8'hED: kb_expect_led = 1'b1;
                8'hEE: resp = 8'hEE;
                8'hF4: kb_enabled = 1'b1;
                8'hF5: kb_enabled = 1'b0;
                default: ;
            endcase
        end
        wait_cycles(10);
        dev_send(resp, 1'b0, 1'b1);
        exp_rx++;
        wait_cycles(4);
        while (kb_enabled && pending.size() > 0) begin
            dev_send(pending.pop_front(), 1'b0, 1'b1);
            exp_rx++;
            wait_cycles(4);
        end
    endtask

    task automatic kb_key(input logic [7:0] b);
        if (kb_enabled) begin
            dev_send(b, 1'b0, 1'b1);
            exp_rx++;
            wait_cycles(4);
        end else begin
            pending.push_back(b);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish within budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] got;
        reset        = 1'b1;
        send_command = 1'b0;
        the_command  = 8'h00;
        wait_cycles(3);
        check("reset busy", busy, 0);
        check("reset received_data", received_data, 8'h00);
        check("reset strobes", {received_data_en, command_was_sent,
                                error_communication_timed_out, error_frame}, 4'b0000);
        check("reset ps2_clk released", ps2_clk, 1);
        check("reset ps2_dat released", ps2_dat, 1);
        reset = 1'b0;
        wait_cycles(3);

        // Scan code 0x1C from the keyboard.
        kb_key(8'h1C);
        check("scan 1C byte", pop_rx(), 8'h1C);
        check("scan 1C held", received_data, 8'h1C);
        check_counts("scan 1C");

        // Echo command.
        do_command(8'hEE, 1'b1, 1'b0, got);
        kb_respond(got);
        check("echo response", pop_rx(), 8'hEE);
        check("echo held", received_data, 8'hEE);
        check_counts("echo");

        // LED command with argument.
        do_command(8'hED, 1'b1, 1'b0, got);
        kb_respond(got);
        check("ED ack", pop_rx(), 8'hFA);
        do_command(8'h07, 1'b0, 1'b0, got);
        kb_respond(got);
        check("LED arg ack", pop_rx(), 8'hFA);
        check("lock_controls", lock_controls, 3'b111);
        check_counts("leds");

        // Disable, key buffered, enable.
        do_command(8'hF5, 1'b1, 1'b0, got);
        kb_respond(got);
        check("F5 ack", pop_rx(), 8'hFA);
        kb_key(8'h1C);
        wait_cycles(50);
        check_counts("while disabled");
        do_command(8'hF4, 1'b0, 1'b0, got);
        kb_respond(got);
        check("F4 ack", pop_rx(), 8'hFA);
        check("buffered key", pop_rx(), 8'h1C);
        check_counts("after enable");

        // Bad parity, then bad stop bit, then recovery.
        dev_send(8'h5A, 1'b1, 1'b1);
        exp_ferr++;
        wait_cycles(4);
        check("bad parity keeps data", received_data, 8'h1C);
        check("bad parity idle", busy, 0);
        check_counts("bad parity");
        dev_send(8'h33, 1'b0, 1'b0);
        exp_ferr++;
        wait_cycles(4);
        check("bad stop keeps data", received_data, 8'h1C);
        check("bad stop idle", busy, 0);
        check_counts("bad stop");
        kb_key(8'h21);
        check("recovery byte", pop_rx(), 8'h21);

        // Missing ACK from the device.
        do_command(8'hF4, 1'b0, 1'b1, got);

        // Transmit timeout: device never clocks; a second request mid-transmit is ignored.
        @(negedge clk);
        the_command  = 8'hF4;
        send_command = 1'b1;
        @(negedge clk);
        send_command = 1'b0;
        wait_cycles(100);
        the_command  = 8'hED;
        send_command = 1'b1;
        @(negedge clk);
        send_command = 1'b0;
        the_command  = 8'h00;
        wait_cycles(94);
        check("tx not yet timed out", tout_cycles, exp_tout);
        check("tx busy before timeout", busy, 1);
        wait_cycles(15);
        exp_tout++;
        check_counts("tx timeout");
        check("tx timeout idle", busy, 0);
        check("tx timeout clk released", ps2_clk, 1);
        check("tx timeout dat released", ps2_dat, 1);

        // Receive timeout: device stops after start + two bits.
        dev_partial(4'b0010, 3);
        check("rx partial busy", busy, 1);
        wait_cycles(150);
        check("rx not yet timed out", tout_cycles, exp_tout);
        wait_cycles(80);
        exp_tout++;
        check_counts("rx timeout");
        check("rx timeout idle", busy, 0);
        dev_dat_low = 1'b0;
        wait_cycles(10);

        // Reset in the middle of a received frame.
        dev_partial(4'b0110, 4);
        check("mid-rx busy", busy, 1);
        reset       = 1'b1;
        dev_dat_low = 1'b0;
        dev_clk_low = 1'b0;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(5);
        check_counts("reset mid-rx");
        check("reset mid-rx idle", busy, 0);
        check("reset mid-rx data cleared", received_data, 8'h00);
        kb_key(8'hA5);
        check("post-reset byte", pop_rx(), 8'hA5);
        check("post-reset held", received_data, 8'hA5);

        check("rx queue drained", rx_q.size(), 0);
        check("strobes exclusive", multi_cycles, 0);
        check_counts("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
